uart_pad_rx: RTL

Parametrised UART receiver and controller-state decoder for the game pad link. It replaces the fixed receive-then-parse pair between the GPIO serial input and `top`. The block oversamples the serial line, validates the start, parity and stop bits, and reports received bytes. It also keeps a held button bitmap with per-bit press pulses, and a link-timeout that releases all buttons when the pad goes silent.

---
 rtl/uart_pad_rx.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_pad_rx.sv
// UART receiver for the game pad link: oversampled framing check plus a held
// button bitmap with press pulses and a silence timeout that drops the link.
module uart_pad_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int HOLD_CYCLES  = 65536
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic [DATA_BITS-1:0] o_buttons,
  output logic [DATA_BITS-1:0] o_pressed,
  output logic                 o_link
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam int TW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_HALF  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [TW-1:0] HOLD_MAX  = TW'(HOLD_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   perr_q, perr_d;
  logic [DATA_BITS-1:0]   data_q, data_d, buttons_q, buttons_d, pressed_q, pressed_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d, perr_out_q, perr_out_d;
  logic                   link_q, link_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   rxd_s, accept, ferr_hit, perr_hit;

  assign rxd_s = sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], i_rxd};
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    perr_d   = perr_q;
    accept   = 1'b0;
    ferr_hit = 1'b0;
    perr_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxd_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          perr_d  = 1'b0;
          state_d = rxd_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shreg_d = {rxd_s, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
          if (bit_q == BIT_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = (PARITY == 2) ? (rxd_s == ^shreg_q) : (rxd_s != ^shreg_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          // A low stop bit masks any parity result and parks us until the line idles.
          if (!rxd_s) begin
            ferr_hit = 1'b1;
            state_d  = S_BREAK;
          end else begin
            perr_hit = perr_q;
            accept   = !perr_q;
            state_d  = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    data_d     = data_q;
    buttons_d  = buttons_q;
    pressed_d  = '0;
    valid_d    = accept;
    ferr_d     = ferr_hit;
    perr_out_d = perr_hit;
    link_d     = link_q;
    timer_d    = timer_q;
    if (HOLD_CYCLES != 0 && link_q) begin
      if (timer_q == HOLD_LAST) begin
        timer_d   = HOLD_MAX;
        link_d    = 1'b0;
        buttons_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
    // Accept overrides a timeout landing in the same cycle.
    if (accept) begin
      data_d    = shreg_q;
      pressed_d = shreg_q & ~buttons_q;
      buttons_d = shreg_q;
      timer_d   = '0;
      link_d    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      buttons_q  <= '0;
      pressed_q  <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_out_q <= 1'b0;
      link_q     <= 1'b0;
      timer_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_out_q <= perr_out_d;
      link_q     <= link_d;
      timer_q    <= timer_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_frame_err  = ferr_q;
  assign o_parity_err = perr_out_q;
  assign o_buttons    = buttons_q;
  assign o_pressed    = pressed_q;
  assign o_link       = link_q;
endmodule
